// File: rtl/vend_multi_fsm_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// State encoding is fixed so it can be probed or matched externally.
package vend_multi_fsm_pkg;

  localparam int MAX_SEL = 16;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DISP   = 3'd2,
    ST_CHANGE = 3'd3
  } state_e;

  // One-hot decode wide enough for the largest supported product count.
  function automatic logic [MAX_SEL-1:0] onehot16(input logic [3:0] idx);
    onehot16 = MAX_SEL'(1) << idx;
  endfunction

endpackage

// File: rtl/vend_disp_timer.sv
// Loadable down-counter timing the dispense pulse; done marks the last
// dispense cycle so the FSM can leave DISP on the following edge.
module vend_disp_timer #(
  parameter int DISP_CYCLES = 10,
  localparam int CNT_W = $clog2(DISP_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(DISP_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vend_multi_fsm.sv
// Multi-product vending controller: credit accumulation, price check,
// timed one-hot dispense, and change/refund return. All outputs registered.
module vend_multi_fsm
  import vend_multi_fsm_pkg::*;
#(
  parameter int NUM_SEL = 4,
  parameter int AMT_W = 8,
  parameter logic [NUM_SEL*AMT_W-1:0] PRICE_TBL = 32'h644B3219,
  parameter int DISP_CYCLES = 10,
  localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               coin_valid,
  input  logic [AMT_W-1:0]   coin_val,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel_idx,
  input  logic               cancel,
  output logic [NUM_SEL-1:0] disp,
  output logic               busy,
  output logic [AMT_W-1:0]   total,
  output logic               coin_reject,
  output logic               sel_err,
  output logic               change_valid,
  output logic [AMT_W-1:0]   change_amt
);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   total_q, total_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SEL-1:0] disp_q, disp_d;
  logic               busy_q, busy_d;
  logic               coin_reject_q, coin_reject_d;
  logic               sel_err_q, sel_err_d;
  logic               change_valid_q, change_valid_d;
  logic [AMT_W-1:0]   change_amt_q, change_amt_d;

  logic [AMT_W-1:0]   price;
  logic               idx_ok;
  logic [AMT_W:0]     sum;
  logic               timer_start;
  logic               timer_done;

  // Loop-based mux keeps the table slice in range for any sel_idx value.
  always_comb begin
    price  = '0;
    idx_ok = (int'(sel_idx) < NUM_SEL);
    for (int i = 0; i < NUM_SEL; i++) begin
      if (int'(sel_idx) == i) price = PRICE_TBL[i*AMT_W +: AMT_W];
    end
  end

  assign sum = {1'b0, total_q} + {1'b0, coin_val};

  vend_disp_timer #(.DISP_CYCLES(DISP_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .done  (timer_done)
  );

  always_comb begin
    state_d        = state_q;
    total_d        = total_q;
    sel_d          = sel_q;
    disp_d         = '0;
    coin_reject_d  = 1'b0;
    sel_err_d      = 1'b0;
    change_valid_d = 1'b0;
    change_amt_d   = '0;
    timer_start    = 1'b0;
    case (state_q)
      ST_INIT: begin
        coin_reject_d = coin_valid;
        if (init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cancel && (total_q != '0)) begin
          coin_reject_d  = coin_valid;
          change_valid_d = 1'b1;
          change_amt_d   = total_q;
          total_d        = '0;
          state_d        = ST_CHANGE;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (!idx_ok || (total_q < price)) begin
            sel_err_d = 1'b1;
          end else begin
            total_d     = total_q - price;
            sel_d       = sel_idx;
            disp_d      = NUM_SEL'(onehot16(4'(sel_idx)));
            timer_start = 1'b1;
            state_d     = ST_DISP;
          end
        end else if (cancel) begin
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          // Overflowing coins bounce back; credit never wraps or saturates.
          if (sum[AMT_W]) coin_reject_d = 1'b1;
          else            total_d = sum[AMT_W-1:0];
        end
      end
      ST_DISP: begin
        coin_reject_d = coin_valid;
        if (timer_done) begin
          if (total_q != '0) begin
            change_valid_d = 1'b1;
            change_amt_d   = total_q;
            total_d        = '0;
            state_d        = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          disp_d = NUM_SEL'(onehot16(4'(sel_q)));
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      total_q        <= '0;
      sel_q          <= '0;
      disp_q         <= '0;
      busy_q         <= 1'b1;
      coin_reject_q  <= 1'b0;
      sel_err_q      <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
    end else begin
      state_q        <= state_d;
      total_q        <= total_d;
      sel_q          <= sel_d;
      disp_q         <= disp_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      sel_err_q      <= sel_err_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
    end
  end

  assign disp         = disp_q;
  assign busy         = busy_q;
  assign total        = total_q;
  assign coin_reject  = coin_reject_q;
  assign sel_err      = sel_err_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;

endmodule

// File: tb/tb_vend_multi_fsm.sv
// Bench for vend_multi_fsm: directed scenarios plus randomized traffic
// compared against a transaction-level vending model.
module tb_vend_multi_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_val = 8'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = 2'd0;
  logic       cancel = 1'b0;
  logic [3:0] disp;
  logic       busy;
  logic [7:0] total;
  logic       coin_reject;
  logic       sel_err;
  logic       change_valid;
  logic [7:0] change_amt;

  int checks = 0;
  int errors = 0;

  // Reference model: machine phase, credit, remaining dispense cycles.
  localparam int M_INIT = 0, M_IDLE = 1, M_DISP = 2, M_CHANGE = 3;
  int price_list [4] = '{25, 50, 75, 100};
  int m_mode = M_INIT;
  int m_credit = 0;
  int m_left = 0;
  int m_sel = 0;
  int e_rej = 0, e_err = 0, e_chg = 0, e_amt = 0;

  vend_multi_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .disp         (disp),
    .busy         (busy),
    .total        (total),
    .coin_reject  (coin_reject),
    .sel_err      (sel_err),
    .change_valid (change_valid),
    .change_amt   (change_amt)
  );

  always #5 clk = ~clk;

  task automatic refund_all();
    e_chg = 1; e_amt = m_credit; m_credit = 0; m_mode = M_CHANGE;
  endtask

  task automatic model_step();
    e_rej = 0; e_err = 0; e_chg = 0; e_amt = 0;
    if (rst) begin
      m_mode = M_INIT; m_credit = 0; m_left = 0;
    end else begin
      case (m_mode)
        M_INIT: begin
          e_rej = int'(coin_valid);
          if (init_done) m_mode = M_IDLE;
        end
        M_IDLE: begin
          if (cancel && m_credit > 0) begin
            e_rej = int'(coin_valid);
            refund_all();
          end else if (sel_valid) begin
            e_rej = int'(coin_valid);
            if (int'(sel_idx) >= 4 || m_credit < price_list[sel_idx]) begin
              e_err = 1;
            end else begin
              m_credit -= price_list[sel_idx];
              m_sel = int'(sel_idx);
              m_left = 10;
              m_mode = M_DISP;
            end
          end else if (cancel) begin
            e_rej = int'(coin_valid);
          end else if (coin_valid) begin
            if (m_credit + int'(coin_val) > 255) e_rej = 1;
            else m_credit += int'(coin_val);
          end
        end
        M_DISP: begin
          e_rej = int'(coin_valid);
          m_left--;
          if (m_left == 0) begin
            if (m_credit > 0) refund_all();
            else m_mode = M_IDLE;
          end
        end
        default: begin
          e_rej = int'(coin_valid);
          m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic put_coin(input int v);
    coin_valid = 1'b1; coin_val = 8'(v);
    cyc();
    coin_valid = 1'b0; coin_val = 8'd0;
  endtask

  task automatic press(input int idx);
    sel_valid = 1'b1; sel_idx = 2'(idx);
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b1 || total !== 8'd0 || disp !== 4'd0 || change_valid !== 1'b0 ||
        change_amt !== 8'd0 || coin_reject !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b total=%0d disp=%b chg=%b amt=%0d rej=%b err=%b",
               busy, total, disp, change_valid, change_amt, coin_reject, sel_err);
    end
    rst = 1'b0;
    put_coin(25);
    checks++;
    if (coin_reject !== 1'b1 || total !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_coin rej=%b total=%0d busy=%b, expected 1/0/1", coin_reject, total, busy);
    end
    init_done = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_exit busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_exact_pay();
    int n = 1;
    bit saw_chg = 0;
    repeat (3) put_coin(25);
    checks++;
    if (total !== 8'd75) begin
      errors++;
      $display("FAIL exact_credit total=%0d, expected 75", total);
    end
    press(2);
    checks++;
    if (total !== 8'd0 || disp !== 4'b0100) begin
      errors++;
      $display("FAIL exact_start total=%0d disp=%b, expected 0/0100", total, disp);
    end
    for (int i = 0; i < 30 && busy; i++) begin
      cyc();
      if (disp === 4'b0100) n++;
      if (change_valid) saw_chg = 1;
    end
    checks++;
    if (n != 10 || saw_chg || busy !== 1'b0) begin
      errors++;
      $display("FAIL exact_disp cycles=%0d chg=%0d busy=%b, expected 10/0/0", n, saw_chg, busy);
    end
  endtask

  task automatic test_change();
    int n = 1;
    bit got = 0;
    int amt = 0;
    put_coin(100);
    put_coin(25);
    press(3);
    checks++;
    if (total !== 8'd25 || disp !== 4'b1000) begin
      errors++;
      $display("FAIL change_start total=%0d disp=%b, expected 25/1000", total, disp);
    end
    for (int i = 0; i < 30 && busy; i++) begin
      cyc();
      if (disp === 4'b1000) n++;
      if (change_valid) begin got = 1; amt = int'(change_amt); end
    end
    checks++;
    if (n != 10 || !got || amt != 25 || total !== 8'd0) begin
      errors++;
      $display("FAIL change_out cycles=%0d got=%0d amt=%0d total=%0d, expected 10/1/25/0",
               n, got, amt, total);
    end
  endtask

  task automatic test_sel_err_cancel();
    put_coin(50);
    press(3);
    checks++;
    if (sel_err !== 1'b1 || total !== 8'd50 || disp !== 4'd0) begin
      errors++;
      $display("FAIL sel_err err=%b total=%0d disp=%b, expected 1/50/0", sel_err, total, disp);
    end
    cancel = 1'b1; cyc(); cancel = 1'b0;
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd50 || total !== 8'd0) begin
      errors++;
      $display("FAIL cancel_refund chg=%b amt=%0d total=%0d, expected 1/50/0",
               change_valid, change_amt, total);
    end
    cyc();
    cancel = 1'b1; cyc(); cancel = 1'b0;
    checks++;
    if (change_valid !== 1'b0 || change_amt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_zero chg=%b amt=%0d busy=%b, expected 0/0/0",
               change_valid, change_amt, busy);
    end
  endtask

  task automatic test_reject();
    bit got = 0;
    int amt = 0;
    put_coin(100);
    put_coin(100);
    put_coin(100);
    checks++;
    if (coin_reject !== 1'b1 || total !== 8'd200) begin
      errors++;
      $display("FAIL overflow rej=%b total=%0d, expected 1/200", coin_reject, total);
    end
    coin_valid = 1'b1; coin_val = 8'd25; sel_valid = 1'b1; sel_idx = 2'd0;
    cyc();
    coin_valid = 1'b0; coin_val = 8'd0; sel_valid = 1'b0;
    checks++;
    if (coin_reject !== 1'b1 || total !== 8'd175 || disp !== 4'b0001) begin
      errors++;
      $display("FAIL coin_with_sel rej=%b total=%0d disp=%b, expected 1/175/0001",
               coin_reject, total, disp);
    end
    put_coin(5);
    checks++;
    if (coin_reject !== 1'b1 || total !== 8'd175) begin
      errors++;
      $display("FAIL coin_in_disp rej=%b total=%0d, expected 1/175", coin_reject, total);
    end
    for (int i = 0; i < 30 && busy; i++) begin
      cyc();
      if (change_valid) begin got = 1; amt = int'(change_amt); end
    end
    checks++;
    if (!got || amt != 175) begin
      errors++;
      $display("FAIL reject_change got=%0d amt=%0d, expected 1/175", got, amt);
    end
    wait_idle();
  endtask

  task automatic test_reset_in_disp();
    put_coin(50);
    put_coin(25);
    press(1);
    repeat (3) cyc();
    checks++;
    if (disp !== 4'b0010) begin
      errors++;
      $display("FAIL disp_cycle4 disp=%b, expected 0010", disp);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (disp !== 4'd0 || busy !== 1'b1 || total !== 8'd0 || change_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset disp=%b busy=%b total=%0d chg=%b, expected 0/1/0/0",
               disp, busy, total, change_valid);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || total !== 8'd0) begin
      errors++;
      $display("FAIL post_reset chg=%b busy=%b total=%0d, expected 0/0/0",
               change_valid, busy, total);
    end
  endtask

  task automatic test_random();
    int coins [7] = '{0, 5, 10, 25, 50, 100, 200};
    logic [3:0] exp_disp;
    for (int c = 0; c < 400; c++) begin
      coin_valid = ($urandom_range(99) < 35);
      coin_val   = 8'(coins[$urandom_range(6)]);
      sel_valid  = ($urandom_range(99) < 15);
      sel_idx    = 2'($urandom_range(3));
      cancel     = ($urandom_range(99) < 5);
      init_done  = ($urandom_range(99) < 92);
      rst        = ($urandom_range(199) == 0);
      cyc();
      exp_disp = (m_mode == M_DISP) ? 4'(1 << m_sel) : 4'd0;
      checks += 7;
      if (disp !== exp_disp) begin
        errors++; $display("FAIL rand_disp cyc %0d got %b want %b", c, disp, exp_disp);
      end
      if (busy !== (m_mode != M_IDLE)) begin
        errors++; $display("FAIL rand_busy cyc %0d got %b want %0d", c, busy, m_mode != M_IDLE);
      end
      if (total !== 8'(m_credit)) begin
        errors++; $display("FAIL rand_total cyc %0d got %0d want %0d", c, total, m_credit);
      end
      if (coin_reject !== e_rej[0]) begin
        errors++; $display("FAIL rand_reject cyc %0d got %b want %0d", c, coin_reject, e_rej);
      end
      if (sel_err !== e_err[0]) begin
        errors++; $display("FAIL rand_sel_err cyc %0d got %b want %0d", c, sel_err, e_err);
      end
      if (change_valid !== e_chg[0]) begin
        errors++; $display("FAIL rand_chg cyc %0d got %b want %0d", c, change_valid, e_chg);
      end
      if (change_amt !== 8'(e_amt)) begin
        errors++; $display("FAIL rand_amt cyc %0d got %0d want %0d", c, change_amt, e_amt);
      end
    end
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; rst = 1'b0; init_done = 1'b1;
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_change();
    test_sel_err_cancel();
    test_reject();
    test_reset_in_disp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
